// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Single-port data RAM controller for a CPU load/store unit. Each request
//   stalls the pipeline through HALT for WAIT_STATES cycles. The access is
//   then committed against a DEPTH_WORDS x 32 little-endian RAM. Misaligned,
//   illegal-size or out-of-range requests make no RAM change and set a
//   sticky error flag. A read that errors returns zero.
//
// Ports
//   CK_REF                  clock, rising edge active
//   int_rst_n               asynchronous active-low reset
//   MEM_ACCESS_VALID        CPU presents a request this cycle
//   MEM_ACCESS_READ_WRN     1 = read, 0 = write
//   MEM_ACCESS_SIZE         00 byte, 01 halfword, 10 word, 11 illegal
//   MEM_ACCESS_ADDRESS_BUS  byte address
//   MEM_ACCESS_DATA_OUT_BUS CPU write data, right-aligned
//   MEM_ACCESS_DATA_IN_BUS  registered read data, right-aligned, zero-filled
//   HALT                    stall request (combinational in the request cycle)
//   MEM_ERR                 sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        CK_REF,
    input  logic        int_rst_n,
    input  logic        MEM_ACCESS_VALID,
    input  logic        MEM_ACCESS_READ_WRN,
    input  logic [1:0]  MEM_ACCESS_SIZE,
    input  logic [15:0] MEM_ACCESS_ADDRESS_BUS,
    input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
    output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
    output logic        HALT,
    output logic        MEM_ERR
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);
    localparam logic        ZERO_WS = (WAIT_STATES == 0);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        halt_s, commit_s, load_s;

    logic        req_rw_r;
    logic [1:0]  req_size_r;
    logic [15:0] req_addr_r;
    logic [31:0] req_data_r;

    logic        sel_rw_s;
    logic [1:0]  sel_size_s;
    logic [15:0] sel_addr_s;
    logic [31:0] sel_data_s;
    logic        sel_err_s;
    logic [AW-1:0] widx_s;
    logic        wr_en_s, rd_en_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, rd_word_s;

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] data_in_r;
    logic        err_r;

    // Misaligned, illegal size, or beyond the end of the RAM.
    function automatic logic access_error(input logic [1:0] size, input logic [15:0] addr);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | ({18'd0, addr[15:2]} >= DEPTH_L);
    endfunction

    // Byte-lane enables for a write of the given size at the given lane.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned write data across the lanes so any enabled lane sees it.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{data[7:0]}};
            2'b01:   d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/halfword/word and right-align it, upper bits zero.
    function automatic logic [31:0] read_lanes(input logic [1:0] size, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [31:0] r;
        case (size)
            2'b00:   r = {24'd0, 8'(word >> {lane, 3'b000})};
            2'b01:   r = lane[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
            2'b10:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // FSM state and wait counter register.
    always_ff @(posedge CK_REF or negedge int_rst_n) begin
        if (!int_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // FSM next state: count down the remaining stall cycles, then return to IDLE.
    always_comb begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
        case (state_r)
            ST_IDLE: begin
                if (MEM_ACCESS_VALID && !ZERO_WS) begin
                    state_s = ST_WAIT;
                    cnt_s   = WS_L - 4'd1;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (cnt_r != 4'd0) begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM outputs: stall, latch-request and commit strobes.
    always_comb begin
        halt_s   = 1'b0;
        commit_s = 1'b0;
        load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (MEM_ACCESS_VALID) begin
                    halt_s   = !ZERO_WS;
                    load_s   = !ZERO_WS;
                    commit_s = ZERO_WS;
                end else begin
                    halt_s   = 1'b0;
                    load_s   = 1'b0;
                    commit_s = 1'b0;
                end
            end
            ST_WAIT: begin
                halt_s   = (cnt_r != 4'd0);
                commit_s = (cnt_r == 4'd0);
            end
            default: begin
                halt_s   = 1'b0;
                commit_s = 1'b0;
            end
        endcase
    end

    // Reset wins over a live VALID so HALT drops the moment reset asserts.
    assign HALT = halt_s & int_rst_n;

    // Latched request fields, captured on the cycle the request is accepted.
    always_ff @(posedge CK_REF or negedge int_rst_n) begin
        if (!int_rst_n) begin
            req_rw_r   <= 1'b1;
            req_size_r <= 2'b00;
            req_addr_r <= 16'd0;
            req_data_r <= 32'd0;
        end else if (load_s) begin
            req_rw_r   <= MEM_ACCESS_READ_WRN;
            req_size_r <= MEM_ACCESS_SIZE;
            req_addr_r <= MEM_ACCESS_ADDRESS_BUS;
            req_data_r <= MEM_ACCESS_DATA_OUT_BUS;
        end else begin
            req_rw_r   <= req_rw_r;
            req_size_r <= req_size_r;
            req_addr_r <= req_addr_r;
            req_data_r <= req_data_r;
        end
    end

    // Access source: latched fields in WAIT, live inputs for zero-wait commits.
    always_comb begin
        if (state_r == ST_WAIT) begin
            sel_rw_s   = req_rw_r;
            sel_size_s = req_size_r;
            sel_addr_s = req_addr_r;
            sel_data_s = req_data_r;
        end else begin
            sel_rw_s   = MEM_ACCESS_READ_WRN;
            sel_size_s = MEM_ACCESS_SIZE;
            sel_addr_s = MEM_ACCESS_ADDRESS_BUS;
            sel_data_s = MEM_ACCESS_DATA_OUT_BUS;
        end
    end

    assign sel_err_s = access_error(sel_size_s, sel_addr_s);
    assign widx_s    = sel_addr_s[AW+1:2];
    assign wr_en_s   = commit_s & int_rst_n & !sel_rw_s & !sel_err_s;
    assign rd_en_s   = commit_s & int_rst_n & sel_rw_s;
    assign be_s      = lane_enables(sel_size_s, sel_addr_s[1:0]);
    assign wdata_s   = lane_data(sel_size_s, sel_data_s);
    assign rd_word_s = mem_r[widx_s];

    // RAM write port; deliberately not reset so contents survive reset.
    always_ff @(posedge CK_REF) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[widx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Read data and sticky error registers, updated on the commit edge.
    always_ff @(posedge CK_REF or negedge int_rst_n) begin
        if (!int_rst_n) begin
            data_in_r <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            if (rd_en_s) begin
                data_in_r <= sel_err_s ? 32'd0 : read_lanes(sel_size_s, sel_addr_s[1:0], rd_word_s);
            end else begin
                data_in_r <= data_in_r;
            end
            err_r <= err_r | (commit_s & sel_err_s);
        end
    end

    assign MEM_ACCESS_DATA_IN_BUS = data_in_r;
    assign MEM_ERR                = err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Table-driven checks of data_mem_ctrl with WAIT_STATES=2. Hand sequences
//   cover reset in the middle of an access and input changes during HALT. A
//   second instance with WAIT_STATES=0 is driven with back-to-back requests.
//   Expected read data is queued when a request is driven and compared when
//   the DUT produces it.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int         WS    = 2;
    localparam logic       READ  = 1'b1;
    localparam logic       WRITE = 1'b0;
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;
    localparam logic [1:0] SZ_X  = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid, rw, halt, err;
    logic [1:0]  sz;
    logic [15:0] addr;
    logic [31:0] wd, dout;

    logic        rst0_n, valid0, rw0, halt0, err0;
    logic [1:0]  sz0;
    logic [15:0] addr0;
    logic [31:0] wd0, dout0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_q[$];
    logic [31:0] sb0_q[$];

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs[17];
    vec_t vecs0[5];

    data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
        .CK_REF                  (clk),
        .int_rst_n               (rst_n),
        .MEM_ACCESS_VALID        (valid),
        .MEM_ACCESS_READ_WRN     (rw),
        .MEM_ACCESS_SIZE         (sz),
        .MEM_ACCESS_ADDRESS_BUS  (addr),
        .MEM_ACCESS_DATA_OUT_BUS (wd),
        .MEM_ACCESS_DATA_IN_BUS  (dout),
        .HALT                    (halt),
        .MEM_ERR                 (err)
    );

    data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .CK_REF                  (clk),
        .int_rst_n               (rst0_n),
        .MEM_ACCESS_VALID        (valid0),
        .MEM_ACCESS_READ_WRN     (rw0),
        .MEM_ACCESS_SIZE         (sz0),
        .MEM_ACCESS_ADDRESS_BUS  (addr0),
        .MEM_ACCESS_DATA_OUT_BUS (wd0),
        .MEM_ACCESS_DATA_IN_BUS  (dout0),
        .HALT                    (halt0),
        .MEM_ERR                 (err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One request on the WAIT_STATES=2 instance. After the request cycle the
    // address switches to alt and the data is inverted; the DUT must ignore both.
    task automatic do_access(input logic r, input logic [1:0] s, input logic [15:0] a,
                             input logic [15:0] alt, input logic [31:0] d,
                             input logic [31:0] exp_d, input logic exp_e, input string name);
        int hc;
        bit done;
        hc   = 0;
        done = 1'b0;
        sb_q.push_back(exp_d);
        @(posedge clk); #1;
        valid = 1'b1; rw = r; sz = s; addr = a; wd = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!halt) begin
                done = 1'b1;
                break;
            end
            hc++;
            @(posedge clk); #1;
            addr = alt;
            wd   = ~d;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: HALT still high after 20 cycles", name);
        end
        check({name, " halt_cycles"}, 32'(hc), 32'(WS));
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check({name, " data"}, dout, sb_q.pop_front());
        check({name, " err"}, {31'd0, err}, {31'd0, exp_e});
        check({name, " halt_idle"}, {31'd0, halt}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{WRITE, SZ_W, 16'h0000, 32'h01020304, 32'h00000000, 1'b0};
        vecs[1]  = '{WRITE, SZ_W, 16'h0010, 32'hCAFEBABE, 32'h00000000, 1'b0};
        vecs[2]  = '{READ,  SZ_W, 16'h0010, 32'h00000000, 32'hCAFEBABE, 1'b0};
        vecs[3]  = '{WRITE, SZ_W, 16'h0020, 32'h11223344, 32'hCAFEBABE, 1'b0};
        vecs[4]  = '{WRITE, SZ_B, 16'h0021, 32'h123456AA, 32'hCAFEBABE, 1'b0};
        vecs[5]  = '{WRITE, SZ_H, 16'h0022, 32'h9999BEEF, 32'hCAFEBABE, 1'b0};
        vecs[6]  = '{READ,  SZ_W, 16'h0020, 32'h00000000, 32'hBEEFAA44, 1'b0};
        vecs[7]  = '{READ,  SZ_B, 16'h0023, 32'h00000000, 32'h000000BE, 1'b0};
        vecs[8]  = '{READ,  SZ_H, 16'h0022, 32'h00000000, 32'h0000BEEF, 1'b0};
        vecs[9]  = '{READ,  SZ_B, 16'h0020, 32'h00000000, 32'h00000044, 1'b0};
        vecs[10] = '{WRITE, SZ_W, 16'h0014, 32'h14141414, 32'h00000044, 1'b0};
        vecs[11] = '{WRITE, SZ_W, 16'h0040, 32'h40404040, 32'h00000044, 1'b0};
        vecs[12] = '{WRITE, SZ_W, 16'h1000, 32'hDEADBEEF, 32'h00000044, 1'b1};
        vecs[13] = '{READ,  SZ_W, 16'h0000, 32'h00000000, 32'h01020304, 1'b1};
        vecs[14] = '{READ,  SZ_W, 16'h0022, 32'h00000000, 32'h00000000, 1'b1};
        vecs[15] = '{WRITE, SZ_X, 16'h0020, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[16] = '{READ,  SZ_W, 16'h0020, 32'h00000000, 32'hBEEFAA44, 1'b1};

        vecs0[0] = '{WRITE, SZ_W, 16'h0100, 32'h11111111, 32'h00000000, 1'b0};
        vecs0[1] = '{WRITE, SZ_W, 16'h0104, 32'h22222222, 32'h00000000, 1'b0};
        vecs0[2] = '{READ,  SZ_W, 16'h0100, 32'h00000000, 32'h11111111, 1'b0};
        vecs0[3] = '{READ,  SZ_W, 16'h0104, 32'h00000000, 32'h22222222, 1'b0};
        vecs0[4] = '{READ,  SZ_B, 16'h0105, 32'h00000000, 32'h00000022, 1'b0};

        rst_n  = 1'b0; valid  = 1'b1; rw  = READ; sz  = SZ_W; addr  = 16'h0; wd  = 32'h0;
        rst0_n = 1'b0; valid0 = 1'b0; rw0 = READ; sz0 = SZ_W; addr0 = 16'h0; wd0 = 32'h0;

        // Reset state, with VALID held high to confirm reset masks HALT.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset halt", {31'd0, halt}, 32'd0);
        check("reset data", dout, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset0 data", dout0, 32'd0);
        valid = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rst0_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            do_access(vecs[i].rw, vecs[i].sz, vecs[i].addr, vecs[i].addr ^ 16'h0008,
                      vecs[i].wd, vecs[i].exp_d, vecs[i].exp_e, $sformatf("vec%0d", i));
        end

        // Reset during the WAIT state of a write to 0x0040.
        @(posedge clk); #1;
        valid = 1'b1; rw = WRITE; sz = SZ_W; addr = 16'h0040; wd = 32'hFFFFFFFF;
        @(negedge clk);
        check("rst_mid halt_req", {31'd0, halt}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid halt_wait", {31'd0, halt}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid halt", {31'd0, halt}, 32'd0);
        check("rst_mid data", dout, 32'd0);
        check("rst_mid err", {31'd0, err}, 32'd0);
        valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_access(READ, SZ_W, 16'h0040, 16'h0040, 32'h0, 32'h40404040, 1'b0, "post_rst_0040");
        do_access(READ, SZ_W, 16'h0010, 16'h0010, 32'h0, 32'hCAFEBABE, 1'b0, "ram_kept_0010");
        do_access(READ, SZ_H, 16'h0031, 16'h0031, 32'h0, 32'h00000000, 1'b1, "half_misalign");
        do_access(WRITE, SZ_W, 16'h0010, 16'h0014, 32'hA5A5A5A5, 32'h00000000, 1'b1, "addr_change");
        do_access(READ, SZ_W, 16'h0010, 16'h0010, 32'h0, 32'hA5A5A5A5, 1'b1, "addr_change_0010");
        do_access(READ, SZ_W, 16'h0014, 16'h0014, 32'h0, 32'h14141414, 1'b1, "addr_change_0014");

        // Zero wait states: one request per cycle, read data one cycle later.
        begin
            bit prev_rd;
            prev_rd = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (c < 5) begin
                    valid0 = 1'b1;
                    rw0    = vecs0[c].rw;
                    sz0    = vecs0[c].sz;
                    addr0  = vecs0[c].addr;
                    wd0    = vecs0[c].wd;
                    if (vecs0[c].rw == READ) sb0_q.push_back(vecs0[c].exp_d);
                end else begin
                    valid0 = 1'b0;
                end
                @(negedge clk);
                check($sformatf("ws0 halt c%0d", c), {31'd0, halt0}, 32'd0);
                if (prev_rd) begin
                    if (sb0_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ws0 scoreboard empty at c%0d", c);
                    end else begin
                        check($sformatf("ws0 data c%0d", c), dout0, sb0_q.pop_front());
                    end
                end
                prev_rd = (c < 5) && (vecs0[c].rw == READ);
            end
            check("ws0 err", {31'd0, err0}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words of RAM.
REQ-002 SHALL have parameter WAIT_STATES, default 2, number of HALT cycles inserted per access (legal 0-15).
REQ-003 SHALL have port CK_REF  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port int_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port MEM_ACCESS_VALID  input  1  CPU requests an access this cycle.
REQ-006 SHALL have port MEM_ACCESS_READ_WRN  input  1  1 = read, 0 = write.
REQ-007 SHALL have port MEM_ACCESS_SIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port MEM_ACCESS_ADDRESS_BUS  input  16  byte address.
REQ-009 SHALL have port MEM_ACCESS_DATA_OUT_BUS  input  32  CPU write data, right-aligned.
REQ-010 SHALL have port MEM_ACCESS_DATA_IN_BUS  output  32  read data to CPU, right-aligned.
REQ-011 SHALL have port HALT  output  1  pipeline stall request to CPU.
REQ-012 SHALL have port MEM_ERR  output  1  sticky error flag.

Function
REQ-013 SHALL store data in a RAM of DEPTH_WORDS x 32 bits, little-endian, word index = address[15:2].
REQ-014 SHALL implement FSM states IDLE and WAIT, plus a 4-bit wait counter.
REQ-015 In IDLE with VALID=1 and WAIT_STATES>0, SHALL drive HALT=1 combinationally, latch READ_WRN/SIZE/ADDRESS/DATA_OUT, load counter with WAIT_STATES-1, and enter WAIT.
REQ-016 In WAIT with counter!=0, SHALL hold HALT=1 and decrement the counter; input changes SHALL be ignored.
REQ-017 In WAIT with counter==0, SHALL drive HALT=0, perform the latched access on the closing edge, and return to IDLE.
REQ-018 With WAIT_STATES=0, SHALL never assert HALT, SHALL perform the access from live inputs on the edge closing the VALID cycle, and SHALL remain in IDLE.
REQ-019 For a request first presented in cycle T, SHALL keep HALT high for exactly WAIT_STATES cycles (T..T+WAIT_STATES-1), commit on the edge ending cycle T+WAIT_STATES, and make read data valid from cycle T+WAIT_STATES+1.
REQ-020 A VALID in the cycle immediately after completion SHALL be treated as a new request.
REQ-021 Writes SHALL update only the addressed lanes: byte writes DATA_OUT[7:0] to lane address[1:0]; halfword writes DATA_OUT[15:0] to lanes address[1]*2 and +1; word writes all four.
REQ-022 Reads SHALL register the selected byte/halfword/word into DATA_IN_BUS right-aligned with upper bits zero; sign extension is left to the CPU.
REQ-023 DATA_IN_BUS SHALL hold its value until the next completed read; writes and errors SHALL not change it.
REQ-024 Misaligned access (halfword with address[0]=1, word with address[1:0]!=0), SIZE=11, or address[15:2]>=DEPTH_WORDS SHALL be an error: no RAM change, read returns 32'h0000_0000, MEM_ERR set to 1 on completion edge.
REQ-025 Erroring accesses SHALL still observe the full WAIT_STATES timing.
REQ-026 MEM_ERR SHALL stay 1 until reset.
REQ-027 VALID=0 in IDLE SHALL cause no RAM access and HALT=0.

Reset
REQ-028 Asserting int_rst_n low SHALL immediately force state IDLE, counter 0, HALT=0, DATA_IN_BUS=0, MEM_ERR=0, including mid-access.
REQ-029 An access aborted by reset SHALL not modify RAM.
REQ-030 RAM contents SHALL not be cleared by reset.
REQ-031 Deassertion SHALL take effect on the next CK_REF rising edge with no extra idle cycles.

Verification
REQ-032 Word write/read, WAIT_STATES=2: write 0xCAFEBABE to 0x0010, then read 0x0010 -> HALT high 2 cycles per access, DATA_IN_BUS=0xCAFEBABE in the 4th cycle after the read is presented (T+3).
REQ-033 Lane writes: word 0x11223344 at 0x0020, byte 0xAA at 0x0021, halfword 0xBEEF at 0x0022 -> word read returns 0xBEEFAA44; byte read at 0x0023 returns 0x000000BE.
REQ-034 Errors: halfword read at 0x0031 -> data 0, MEM_ERR=1, RAM unchanged; with DEPTH_WORDS=1024, word write to 0x1000 -> RAM unchanged.
REQ-035 WAIT_STATES=0: back-to-back writes on consecutive cycles -> HALT never high, both committed.
REQ-036 Reset mid-access: pull int_rst_n low in the WAIT state of a write to 0x0040 -> HALT drops immediately, and a read after reset returns the old value at 0x0040.
REQ-037 Input change during HALT: change address from 0x0010 to 0x0014 mid-WAIT -> access targets 0x0010.
